// File: rtl/mips_harvard_cpu.sv
// Single-cycle MIPS-I subset core with separate instruction/data buses and one branch delay slot.
// Optional byte/halfword loads (LB/LBU/LH/LHU) are enabled by defining MIPS_CPU_SUBWORD_LOADS_EN.
module mips_harvard_cpu #(
    parameter logic [31:0] RESET_VECTOR = 32'hBFC00000
) (
    input  logic        clk,
    input  logic        reset,
    output logic        active,
    output logic [31:0] register_v0,
    input  logic        clk_enable,
    output logic [31:0] instr_address,
    input  logic [31:0] instr_readdata,
    output logic [31:0] data_address,
    output logic        data_write,
    output logic        data_read,
    output logic [31:0] data_writedata,
    input  logic [31:0] data_readdata
);
    localparam logic [5:0] OP_RTYPE = 6'h00, OP_J    = 6'h02, OP_JAL   = 6'h03, OP_BEQ  = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05, OP_BLEZ = 6'h06, OP_BGTZ  = 6'h07, OP_ADDIU = 6'h09;
    localparam logic [5:0] OP_SLTI  = 6'h0A, OP_SLTIU = 6'h0B, OP_ANDI = 6'h0C, OP_ORI  = 6'h0D;
    localparam logic [5:0] OP_XORI  = 6'h0E, OP_LUI  = 6'h0F, OP_LW    = 6'h23, OP_SW   = 6'h2B;
`ifdef MIPS_CPU_SUBWORD_LOADS_EN
    localparam logic [5:0] OP_LB = 6'h20, OP_LH = 6'h21, OP_LBU = 6'h24, OP_LHU = 6'h25;
`endif
    localparam logic [5:0] F_SLL  = 6'h00, F_SRL  = 6'h02, F_SRA  = 6'h03, F_SLLV = 6'h04;
    localparam logic [5:0] F_SRLV = 6'h06, F_SRAV = 6'h07, F_JR   = 6'h08, F_JALR = 6'h09;
    localparam logic [5:0] F_ADDU = 6'h21, F_SUBU = 6'h23, F_AND  = 6'h24, F_OR   = 6'h25;
    localparam logic [5:0] F_XOR  = 6'h26, F_NOR  = 6'h27, F_SLT  = 6'h2A, F_SLTU = 6'h2B;

    logic [31:0] pc, npc;
    logic [31:0] regs [32];
    logic        en;

    logic [5:0]  op, funct;
    logic [4:0]  rs, rt, rd, shamt;
    logic [31:0] rs_val, rt_val, simm, zimm, pc4, ea;

    logic        wb_en, br_taken, is_load, is_store, is_subword;
    logic [4:0]  wb_addr;
    logic [31:0] wb_data, br_target;

    // An undriven or unknown enable counts as running.
    assign en = (clk_enable !== 1'b0);

    assign op     = instr_readdata[31:26];
    assign rs     = instr_readdata[25:21];
    assign rt     = instr_readdata[20:16];
    assign rd     = instr_readdata[15:11];
    assign shamt  = instr_readdata[10:6];
    assign funct  = instr_readdata[5:0];
    assign simm   = {{16{instr_readdata[15]}}, instr_readdata[15:0]};
    assign zimm   = {16'h0000, instr_readdata[15:0]};
    assign rs_val = regs[rs];
    assign rt_val = regs[rt];
    assign pc4    = pc + 32'd4;
    assign ea     = rs_val + simm;

`ifdef MIPS_CPU_SUBWORD_LOADS_EN
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;
    assign ld_byte = 8'(data_readdata >> {ea[1:0], 3'b000});
    assign ld_half = 16'(data_readdata >> {ea[1], 4'b0000});
`endif

    // Decode and execute: write-back selection and control-flow target.
    always_comb begin
        wb_en      = 1'b0;
        wb_addr    = rt;
        wb_data    = '0;
        br_taken   = 1'b0;
        br_target  = pc4 + (simm << 2);
        is_load    = 1'b0;
        is_store   = 1'b0;
        is_subword = 1'b0;
        case (op)
            OP_RTYPE: begin
                wb_en   = 1'b1;
                wb_addr = rd;
                case (funct)
                    F_SLL:  wb_data = rt_val << shamt;
                    F_SRL:  wb_data = rt_val >> shamt;
                    F_SRA:  wb_data = 32'($signed(rt_val) >>> shamt);
                    F_SLLV: wb_data = rt_val << rs_val[4:0];
                    F_SRLV: wb_data = rt_val >> rs_val[4:0];
                    F_SRAV: wb_data = 32'($signed(rt_val) >>> rs_val[4:0]);
                    F_JR: begin
                        wb_en     = 1'b0;
                        br_taken  = 1'b1;
                        br_target = rs_val;
                    end
                    F_JALR: begin
                        wb_data   = pc + 32'd8;
                        br_taken  = 1'b1;
                        br_target = rs_val;
                    end
                    F_ADDU: wb_data = rs_val + rt_val;
                    F_SUBU: wb_data = rs_val - rt_val;
                    F_AND:  wb_data = rs_val & rt_val;
                    F_OR:   wb_data = rs_val | rt_val;
                    F_XOR:  wb_data = rs_val ^ rt_val;
                    F_NOR:  wb_data = ~(rs_val | rt_val);
                    F_SLT:  wb_data = {31'd0, $signed(rs_val) < $signed(rt_val)};
                    F_SLTU: wb_data = {31'd0, rs_val < rt_val};
                    default: wb_en = 1'b0;
                endcase
            end
            OP_J, OP_JAL: begin
                br_taken  = 1'b1;
                br_target = {pc4[31:28], instr_readdata[25:0], 2'b00};
                wb_en     = (op == OP_JAL);
                wb_addr   = 5'd31;
                wb_data   = pc + 32'd8;
            end
            OP_BEQ:   br_taken = (rs_val == rt_val);
            OP_BNE:   br_taken = (rs_val != rt_val);
            OP_BLEZ:  br_taken = ($signed(rs_val) <= 0);
            OP_BGTZ:  br_taken = ($signed(rs_val) > 0);
            OP_ADDIU: begin wb_en = 1'b1; wb_data = ea; end
            OP_SLTI:  begin wb_en = 1'b1; wb_data = {31'd0, $signed(rs_val) < $signed(simm)}; end
            OP_SLTIU: begin wb_en = 1'b1; wb_data = {31'd0, rs_val < simm}; end
            OP_ANDI:  begin wb_en = 1'b1; wb_data = rs_val & zimm; end
            OP_ORI:   begin wb_en = 1'b1; wb_data = rs_val | zimm; end
            OP_XORI:  begin wb_en = 1'b1; wb_data = rs_val ^ zimm; end
            OP_LUI:   begin wb_en = 1'b1; wb_data = {instr_readdata[15:0], 16'h0000}; end
            OP_LW:    begin wb_en = 1'b1; is_load = 1'b1; wb_data = data_readdata; end
            OP_SW:    is_store = 1'b1;
`ifdef MIPS_CPU_SUBWORD_LOADS_EN
            OP_LB: begin
                wb_en = 1'b1; is_load = 1'b1; is_subword = 1'b1;
                wb_data = {{24{ld_byte[7]}}, ld_byte};
            end
            OP_LBU: begin
                wb_en = 1'b1; is_load = 1'b1; is_subword = 1'b1;
                wb_data = {24'd0, ld_byte};
            end
            OP_LH: begin
                wb_en = 1'b1; is_load = 1'b1; is_subword = 1'b1;
                wb_data = {{16{ld_half[15]}}, ld_half};
            end
            OP_LHU: begin
                wb_en = 1'b1; is_load = 1'b1; is_subword = 1'b1;
                wb_data = {16'd0, ld_half};
            end
`endif
            default: ;
        endcase
    end

    assign instr_address  = pc;
    assign register_v0    = regs[2];
    assign data_writedata = rt_val;
    assign data_address   = is_subword ? {ea[31:2], 2'b00} : ea;
    assign data_read      = active & is_load;
    assign data_write     = active & en & is_store;

    // Architectural state; reaching PC 0 through the delay slot halts the core.
    always_ff @(posedge clk) begin
        if (reset) begin
            pc     <= RESET_VECTOR;
            npc    <= RESET_VECTOR + 32'd4;
            active <= 1'b1;
            for (int i = 0; i < 32; i++) regs[i] <= '0;
        end else if (en && active) begin
            pc  <= npc;
            npc <= br_taken ? br_target : npc + 32'd4;
            if (npc == '0) active <= 1'b0;
            if (wb_en && wb_addr != 5'd0) regs[wb_addr] <= wb_data;
        end
    end
endmodule

// File: tb/tb_mips_harvard_cpu.sv
// Self-checking bench for mips_harvard_cpu: directed scenarios plus random instruction
// streams compared against an instruction-level reference model of the architecture.
module tb_mips_harvard_cpu;
    logic        clk = 1'b0;
    logic        reset;
    logic        active;
    logic [31:0] register_v0;
    logic        clk_enable;
    logic [31:0] instr_address;
    logic [31:0] instr_readdata;
    logic [31:0] data_address;
    logic        data_write;
    logic        data_read;
    logic [31:0] data_writedata;
    logic [31:0] data_readdata;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference architectural state.
    logic [31:0] m_pc, m_npc;
    logic [31:0] m_regs [32];
    logic        m_active;

    mips_harvard_cpu dut (
        .clk            (clk),
        .reset          (reset),
        .active         (active),
        .register_v0    (register_v0),
        .clk_enable     (clk_enable),
        .instr_address  (instr_address),
        .instr_readdata (instr_readdata),
        .data_address   (data_address),
        .data_write     (data_write),
        .data_read      (data_read),
        .data_writedata (data_writedata),
        .data_readdata  (data_readdata)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] enc_i(input logic [5:0] op, input logic [4:0] rs,
                                          input logic [4:0] rt, input logic [15:0] imm);
        return {op, rs, rt, imm};
    endfunction

    function automatic logic [31:0] enc_r(input logic [4:0] rs, input logic [4:0] rt,
                                          input logic [4:0] rd, input logic [4:0] sh,
                                          input logic [5:0] fn);
        return {6'd0, rs, rt, rd, sh, fn};
    endfunction

    function automatic logic [31:0] sext16(input logic [15:0] v);
        return {{16{v[15]}}, v};
    endfunction

    function automatic logic is_subword_op(input logic [5:0] op);
`ifdef MIPS_CPU_SUBWORD_LOADS_EN
        return op == 6'h20 || op == 6'h21 || op == 6'h24 || op == 6'h25;
`else
        return op != op;
`endif
    endfunction

    // One instruction's architectural effect, straight from the ISA rules.
    task automatic model_exec(input logic [31:0] ins, input logic [31:0] rdata, input logic en);
        logic [5:0]  op;
        logic [5:0]  fn;
        logic [4:0]  dest;
        logic [31:0] a, b, si, ea, val, target, pc4;
        logic        wr;
        if (!(en && m_active)) return;
        op = ins[31:26]; fn = ins[5:0];
        a  = m_regs[ins[25:21]]; b = m_regs[ins[20:16]];
        si = sext16(ins[15:0]); ea = a + si; pc4 = m_pc + 4;
        target = m_npc + 4; wr = 1'b0; dest = ins[20:16]; val = 0;
        if (op == 0) begin
            wr = 1'b1; dest = ins[15:11];
            case (fn)
                6'h00: val = b << ins[10:6];
                6'h02: val = b >> ins[10:6];
                6'h03: val = $signed(b) >>> ins[10:6];
                6'h04: val = b << a[4:0];
                6'h06: val = b >> a[4:0];
                6'h07: val = $signed(b) >>> a[4:0];
                6'h08: begin wr = 1'b0; target = a; end
                6'h09: begin val = m_pc + 8; target = a; end
                6'h21: val = a + b;
                6'h23: val = a - b;
                6'h24: val = a & b;
                6'h25: val = a | b;
                6'h26: val = a ^ b;
                6'h27: val = ~(a | b);
                6'h2A: val = ($signed(a) < $signed(b)) ? 1 : 0;
                6'h2B: val = (a < b) ? 1 : 0;
                default: wr = 1'b0;
            endcase
        end else begin
            case (op)
                6'h02: target = {pc4[31:28], ins[25:0], 2'b00};
                6'h03: begin target = {pc4[31:28], ins[25:0], 2'b00}; wr = 1'b1; dest = 31; val = m_pc + 8; end
                6'h04: if (a == b) target = pc4 + si * 4;
                6'h05: if (a != b) target = pc4 + si * 4;
                6'h06: if ($signed(a) <= 0) target = pc4 + si * 4;
                6'h07: if ($signed(a) > 0) target = pc4 + si * 4;
                6'h09: begin wr = 1'b1; val = ea; end
                6'h0A: begin wr = 1'b1; val = ($signed(a) < $signed(si)) ? 1 : 0; end
                6'h0B: begin wr = 1'b1; val = (a < si) ? 1 : 0; end
                6'h0C: begin wr = 1'b1; val = a & {16'd0, ins[15:0]}; end
                6'h0D: begin wr = 1'b1; val = a | {16'd0, ins[15:0]}; end
                6'h0E: begin wr = 1'b1; val = a ^ {16'd0, ins[15:0]}; end
                6'h0F: begin wr = 1'b1; val = ins[15:0] * 32'h10000; end
                6'h23: begin wr = 1'b1; val = rdata; end
                default: begin
                    if (is_subword_op(op)) begin
                        wr = 1'b1;
                        if (op[0]) val = (rdata >> (16 * ea[1])) & 32'hFFFF;
                        else       val = (rdata >> (8 * ea[1:0])) & 32'hFF;
                        if (op == 6'h20 && val[7])  val = val | 32'hFFFFFF00;
                        if (op == 6'h21 && val[15]) val = val | 32'hFFFF0000;
                    end
                end
            endcase
        end
        if (wr && dest != 0) m_regs[dest] = val;
        m_pc  = m_npc;
        m_npc = target;
        if (m_pc == 0) m_active = 1'b0;
    endtask

    // Present one instruction for one cycle and check bus outputs, then post-edge state.
    task automatic step(input logic [31:0] ins, input logic [31:0] rdata, input logic en);
        logic [5:0]  op;
        logic        ld, st;
        logic [31:0] ea;
        instr_readdata = ins; data_readdata = rdata; clk_enable = en;
        #1;
        op = ins[31:26];
        ld = (op == 6'h23) || is_subword_op(op);
        st = (op == 6'h2B);
        ea = m_regs[ins[25:21]] + sext16(ins[15:0]);
        if (is_subword_op(op)) ea = ea & 32'hFFFFFFFC;
        chk("data_read", 32'(data_read), 32'(m_active && ld));
        chk("data_write", 32'(data_write), 32'(m_active && en && st));
        chk("data_writedata", data_writedata, m_regs[ins[20:16]]);
        if (m_active && (ld || st)) chk("data_address", data_address, ea);
        model_exec(ins, rdata, en);
        @(posedge clk); #1;
        chk("instr_address", instr_address, m_pc);
        chk("register_v0", register_v0, m_regs[2]);
        chk("active", 32'(active), 32'(m_active));
    endtask

    task automatic do_reset();
        reset = 1'b1; instr_readdata = 0; data_readdata = 0; clk_enable = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        m_pc = 32'hBFC00000; m_npc = 32'hBFC00004; m_active = 1'b1;
        for (int i = 0; i < 32; i++) m_regs[i] = 0;
        chk("rst_instr_address", instr_address, 32'hBFC00000);
        chk("rst_active", 32'(active), 32'd1);
        chk("rst_v0", register_v0, 32'd0);
    endtask

    logic [5:0] op_pool [26] = '{6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h09, 6'h0A, 6'h0B,
                                 6'h0C, 6'h0D, 6'h0E, 6'h0F, 6'h04, 6'h05, 6'h06, 6'h07, 6'h23,
                                 6'h2B, 6'h02, 6'h03, 6'h20, 6'h21, 6'h24, 6'h25, 6'h3F};
    logic [5:0] fn_pool [15] = '{6'h00, 6'h02, 6'h03, 6'h04, 6'h06, 6'h07, 6'h21, 6'h23, 6'h24,
                                 6'h25, 6'h26, 6'h27, 6'h2A, 6'h2B, 6'h01};

    initial begin
        logic [31:0] p, ins, v0_hold;
        logic [5:0]  op;

        do_reset();
        step(32'h0, 32'h0, 1'b1);
        chk("first_advance", instr_address, 32'hBFC00004);

        // Load then store of the loaded value.
        step(32'h8C080064, 32'd9, 1'b1);
        step(32'hAC080000, 32'h0, 1'b1);
        chk("sw_writedata", data_writedata, 32'd9);

        step(enc_i(6'h09, 0, 2, 16'd5), 0, 1'b1);
        chk("addiu_5", register_v0, 32'd5);
        step(enc_r(2, 2, 2, 0, 6'h21), 0, 1'b1);
        chk("addu_10", register_v0, 32'd10);
        step(enc_i(6'h09, 0, 2, 16'hFFFF), 0, 1'b1);
        chk("addiu_m1", register_v0, 32'hFFFFFFFF);

        // Taken branch with a delay slot that still executes.
        p = instr_address;
        step(enc_i(6'h04, 0, 0, 16'd3), 0, 1'b1);
        step(enc_i(6'h09, 0, 2, 16'd7), 0, 1'b1);
        chk("delay_slot_v0", register_v0, 32'd7);
        chk("branch_target", instr_address, p + 32'd16);

        // Stall: nothing moves for three cycles.
        p = instr_address;
        for (int i = 0; i < 3; i++) begin
            step(enc_i(6'h09, 0, 2, 16'd3), 0, 1'b0);
            chk("stall_v0", register_v0, 32'd7);
            chk("stall_pc", instr_address, p);
        end
        step(enc_i(6'h09, 0, 2, 16'd3), 0, 1'b1);
        chk("resume_v0", register_v0, 32'd3);

        // Random instruction stream on a small register window.
        for (int n = 0; n < 600; n++) begin
            op = op_pool[$urandom_range(0, 25)];
            if (op == 6'h00)
                ins = enc_r(5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                            5'($urandom_range(0, 7)), 5'($urandom),
                            fn_pool[$urandom_range(0, 14)]);
            else if (op == 6'h02 || op == 6'h03)
                ins = {op, 26'($urandom)};
            else
                ins = enc_i(op, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 16'($urandom));
            step(ins, $urandom, ($urandom_range(0, 9) != 0));
        end

        // JALR link then a jump back through the link register.
        step(enc_i(6'h0F, 0, 9, 16'hBFC0), 0, 1'b1);
        p = instr_address;
        step(enc_r(9, 0, 31, 0, 6'h09), 0, 1'b1);
        step(32'h0, 0, 1'b1);
        chk("jalr_target", instr_address, 32'hBFC00000);
        step(enc_r(31, 0, 2, 0, 6'h21), 0, 1'b1);
        chk("jalr_link", register_v0, p + 32'd8);

        // Halt via JR $0 and its delay slot.
        step(enc_r(0, 0, 0, 0, 6'h08), 0, 1'b1);
        step(32'h0, 0, 1'b1);
        chk("halt_active", 32'(active), 32'd0);
        chk("halt_pc", instr_address, 32'd0);
        v0_hold = register_v0;
        for (int i = 0; i < 4; i++) begin
            step(enc_i(6'h2B, 0, 2, 16'd4), 0, 1'b1);
            step(enc_i(6'h09, 0, 2, 16'd1), 0, 1'b1);
        end
        chk("halt_v0_frozen", register_v0, v0_hold);

        // Reset out of halt restarts from the vector.
        do_reset();
        step(32'h0, 32'h0, 1'b1);
        chk("restart_advance", instr_address, 32'hBFC00004);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
